mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one physical-memory port between instruction-cache misses (I-side, read-only) and data-cache misses (D-side, read/write) in the pipelined LC-3b.
- Sits between the two L1 caches and physical memory.
- Serialises line transfers so that fetch and MEM-stage misses never drive the memory port together.
- Uses fair alternation under contention, so neither fetch nor MEM stalls forever.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits (8 words).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-side line address.
- i_rdata  out  LINE_WIDTH  line returned to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write-back request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-side line address.
- d_wdata  in  LINE_WIDTH  write-back line.
- d_rdata  out  LINE_WIDTH  line returned to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe; held until pmem_resp.
- pmem_write  out  1  memory write strobe; held until pmem_resp.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- FSM states:
  - IDLE: requests are sampled only here.
  - BUSY_I
  - BUSY_D
  - DONE: response cycle.
- Reset:
  - State goes to IDLE; last_grant = I.
  - All outputs 0: pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata, i_rdata, d_rdata.
  - Reset mid-transaction abandons the transfer. pmem strobes drop at the edge after reset is sampled, and no resp is issued. Requesters reissue.
- Grant rules in IDLE:
  - Only i_read pending: grant I.
  - Only d_read or d_write pending: grant D.
  - Both pending: grant the side not equal to last_grant. After reset, D wins the first conflict.
  - On grant: latch address (and d_wdata, plus op = write if d_write, else read) into registers. Update last_grant. Go to BUSY_x.
- BUSY_x:
  - Drive pmem_read or pmem_write = 1 from the registered op, with registered pmem_address and pmem_wdata. Strobes are registered outputs and stay stable the whole busy period.
  - On pmem_resp: capture pmem_rdata into i_rdata (I) or d_rdata (D read only; a D write leaves d_rdata unchanged). Drop strobes at the same edge. Go to DONE.
- DONE:
  - Assert exactly one of i_resp / d_resp for one cycle. Next state is IDLE.
  - Requests present in DONE are ignored. A requester must deassert in the cycle it sees resp, so the earliest back-to-back grant is the IDLE cycle after DONE.
- Latency:
  - Request seen in IDLE at cycle 0; strobe high from cycle 1.
  - pmem_resp at cycle 1+L; x_resp at cycle 2+L.
  - Minimum 3 cycles when L = 1. Never more than one memory transaction outstanding.
- Data hold:
  - i_rdata and d_rdata hold their last captured values until the next completion of the same side.
- Boundary conditions:
  - pmem_resp while in IDLE or DONE: ignored.
  - d_read and d_write both high: treated as write. This is a simulation assertion error.
  - A request dropped before grant is simply not served. A request dropped after grant still completes and pulses resp.
  - Requests arriving while BUSY wait; priority is evaluated at the next IDLE.

Decomposition:
- Add to lc3b_types:
  - lc3b_line (logic [127:0]).
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, DONE}.
  - arb_side_t enum {SIDE_I, SIDE_D}.
- One natural sub-module: mem_arbiter_control.
  - Contains the FSM, last_grant, grant decode, and load enables.
  - The top level holds the address, wdata and rdata registers, reusing the existing register module with width override.

Test Plan:
- I-only read, pmem_resp after 4 cycles, i_address=0x1230, pmem_rdata=0xA5..A5 -> pmem_read high cycles 1-5 with pmem_address=0x1230; i_resp single pulse at cycle 6 with i_rdata=0xA5..A5; d_resp stays 0.
- D write-back, d_address=0x4000, d_wdata=0x0123..CDEF, L=1 -> pmem_write=1 with the same address and data, pmem_read=0; d_resp at cycle 3; d_rdata unchanged.
- i_read and d_read raised in the same cycle after reset -> D served first (pmem_address=d_address), then I granted in the IDLE after DONE; a second simultaneous pair is granted I then D (alternation).
- Reset asserted in BUSY_D with pmem_resp never returned -> next cycle pmem_read=0, state IDLE, no d_resp; a subsequent i_read completes normally.
- Spurious pmem_resp in IDLE, plus a request held through DONE -> no resp pulse from the spurious pmem_resp; no duplicate grant during DONE; the held request is regranted only in the following IDLE.
- d_read and d_write both high -> write performed, assertion fires.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter.
//   lc3b_word   : 16-bit byte address
//   lc3b_line   : 128-bit cache line (8 words)
//   arb_state_t : arbiter FSM states
//   arb_side_t  : which requester owns the memory port
//   pick_side() : grant decision for the IDLE state
package mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} arb_state_t;
  typedef enum logic {SIDE_I, SIDE_D} arb_side_t;

  // A lone requester always wins; under contention the side that was not
  // granted last time wins, so fetch and MEM alternate and neither starves.
  function automatic arb_side_t pick_side(input logic      i_req,
                                          input logic      d_req,
                                          input arb_side_t last);
    arb_side_t side;
    if (i_req && d_req) begin
      side = (last == SIDE_I) ? SIDE_D : SIDE_I;
    end else if (d_req) begin
      side = SIDE_D;
    end else begin
      side = SIDE_I;
    end
    return side;
  endfunction

endpackage

// File: rtl/mem_arbiter_control.sv
// Arbiter FSM: samples requests in IDLE, owns last_grant, drives the
// registered memory strobes and produces load enables for the datapath
// registers held in the top level.
//   clk, reset        : clock and synchronous active-high reset
//   i_read            : I-cache read request
//   d_read, d_write   : D-cache read / write-back request
//   pmem_resp         : memory completion pulse
//   o_grant           : grant this cycle (load address register)
//   o_grant_side      : side being granted (valid with o_grant)
//   o_ld_i_rdata      : capture pmem_rdata into i_rdata
//   o_ld_d_rdata      : capture pmem_rdata into d_rdata
//   o_pmem_read/write : registered memory strobes
//   o_i_resp/o_d_resp : one-cycle completion pulses
module mem_arbiter_control
  import mem_arbiter_pkg::*;
#(
  parameter bit DUAL_OP_CHECK = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_read,
  input  logic      d_read,
  input  logic      d_write,
  input  logic      pmem_resp,
  output logic      o_grant,
  output arb_side_t o_grant_side,
  output logic      o_ld_i_rdata,
  output logic      o_ld_d_rdata,
  output logic      o_pmem_read,
  output logic      o_pmem_write,
  output logic      o_i_resp,
  output logic      o_d_resp
);

  arb_state_t r_state, w_state_next;
  arb_side_t  r_last_grant, w_last_grant_next;
  logic       r_op_write, w_op_write_next;
  logic       r_pmem_read, w_pmem_read_next;
  logic       r_pmem_write, w_pmem_write_next;
  logic       w_i_req, w_d_req;
  arb_side_t  w_side;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;
  assign w_side  = pick_side(w_i_req, w_d_req, r_last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= SIDE_I;
      r_op_write   <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_op_write   <= w_op_write_next;
      r_pmem_read  <= w_pmem_read_next;
      r_pmem_write <= w_pmem_write_next;
    end
  end

  // Simultaneous d_read/d_write is a requester bug; it is served as a write.
  always_ff @(posedge clk) begin
    if (DUAL_OP_CHECK && !reset && (r_state == IDLE)) begin
      assert (!(d_read && d_write))
        else $error("mem_arbiter: d_read and d_write both high");
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_op_write_next   = r_op_write;
    w_pmem_read_next  = r_pmem_read;
    w_pmem_write_next = r_pmem_write;
    o_grant           = 1'b0;
    o_grant_side      = w_side;
    o_ld_i_rdata      = 1'b0;
    o_ld_d_rdata      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_i_req || w_d_req) begin
          o_grant           = 1'b1;
          w_last_grant_next = w_side;
          if (w_side == SIDE_D) begin
            w_op_write_next   = d_write;
            w_pmem_read_next  = ~d_write;
            w_pmem_write_next = d_write;
            w_state_next      = BUSY_D;
          end else begin
            w_op_write_next   = 1'b0;
            w_pmem_read_next  = 1'b1;
            w_pmem_write_next = 1'b0;
            w_state_next      = BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          o_ld_i_rdata      = 1'b1;
          w_pmem_read_next  = 1'b0;
          w_pmem_write_next = 1'b0;
          w_state_next      = DONE;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          // A write-back returns nothing; d_rdata keeps its old line.
          o_ld_d_rdata      = ~r_op_write;
          w_pmem_read_next  = 1'b0;
          w_pmem_write_next = 1'b0;
          w_state_next      = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next      = IDLE;
        w_pmem_read_next  = 1'b0;
        w_pmem_write_next = 1'b0;
      end
    endcase
  end

  assign o_pmem_read  = r_pmem_read;
  assign o_pmem_write = r_pmem_write;
  // last_grant names the side just served, so it selects the response.
  assign o_i_resp     = (r_state == DONE) && (r_last_grant == SIDE_I);
  assign o_d_resp     = (r_state == DONE) && (r_last_grant == SIDE_D);

endmodule

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high reset to zero.
//   clk, reset : clock and synchronous reset
//   i_load     : capture i_d on the rising edge
//   i_d        : data in
//   o_q        : registered data out
module register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single physical-memory port between I-cache line reads and
// D-cache line reads/write-backs, one transaction at a time, alternating
// under contention.
//   clk, reset                      : clock, synchronous active-high reset
//   i_read, i_address               : I-side request
//   i_rdata, i_resp                 : I-side returned line and completion
//   d_read, d_write, d_address,
//   d_wdata                         : D-side request
//   d_rdata, d_resp                 : D-side returned line and completion
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata        : memory request (registered)
//   pmem_rdata, pmem_resp           : memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter bit          DUAL_OP_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  logic                  w_grant;
  arb_side_t             w_grant_side;
  logic                  w_ld_i_rdata;
  logic                  w_ld_d_rdata;
  logic                  w_ld_wdata;
  logic [ADDR_WIDTH-1:0] w_addr_in;

  mem_arbiter_control #(
    .DUAL_OP_CHECK(DUAL_OP_CHECK)
  ) u_control (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .d_read       (d_read),
    .d_write      (d_write),
    .pmem_resp    (pmem_resp),
    .o_grant      (w_grant),
    .o_grant_side (w_grant_side),
    .o_ld_i_rdata (w_ld_i_rdata),
    .o_ld_d_rdata (w_ld_d_rdata),
    .o_pmem_read  (pmem_read),
    .o_pmem_write (pmem_write),
    .o_i_resp     (i_resp),
    .o_d_resp     (d_resp)
  );

  assign w_addr_in  = (w_grant_side == SIDE_D) ? d_address : i_address;
  assign w_ld_wdata = w_grant && (w_grant_side == SIDE_D);

  register #(
    .WIDTH(ADDR_WIDTH)
  ) u_addr_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_grant),
    .i_d    (w_addr_in),
    .o_q    (pmem_address)
  );

  register #(
    .WIDTH(LINE_WIDTH)
  ) u_wdata_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ld_wdata),
    .i_d    (d_wdata),
    .o_q    (pmem_wdata)
  );

  register #(
    .WIDTH(LINE_WIDTH)
  ) u_i_rdata_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ld_i_rdata),
    .i_d    (pmem_rdata),
    .o_q    (i_rdata)
  );

  register #(
    .WIDTH(LINE_WIDTH)
  ) u_d_rdata_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ld_d_rdata),
    .i_d    (pmem_rdata),
    .o_q    (d_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are checked on the
// falling edge; "cycle N" counts rising edges after the request is first seen.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] exp_i_rdata;
  logic [LW-1:0] exp_d_rdata;
  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_wb;
  logic [LW-1:0] line_x;

  mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .LINE_WIDTH   (LW),
    .DUAL_OP_CHECK(1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    line_a5    = {16{8'hA5}};
    line_wb    = {2{64'h0123_4567_89AB_CDEF}};
    line_x     = {4{32'hDEAD_BEEF}};
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    repeat (3) cyc();

    // Reset state
    chk1("rst_pmem_read", pmem_read, 1'b0);
    chk1("rst_pmem_write", pmem_write, 1'b0);
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    chk16("rst_pmem_address", pmem_address, 16'h0000);
    chkl("rst_pmem_wdata", pmem_wdata, '0);
    chkl("rst_i_rdata", i_rdata, '0);
    chkl("rst_d_rdata", d_rdata, '0);

    // T1: I-only read, memory answers in cycle 5
    reset     = 1'b0;
    i_read    = 1'b1;
    i_address = 16'h1230;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      chk1("t1_pmem_read", pmem_read, 1'b1);
      chk16("t1_pmem_address", pmem_address, 16'h1230);
      chk1("t1_i_resp_early", i_resp, 1'b0);
      cyc();
    end
    chk1("t1_pmem_read_c5", pmem_read, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = line_a5;
    cyc();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    exp_i_rdata = line_a5;
    chk1("t1_i_resp", i_resp, 1'b1);
    chkl("t1_i_rdata", i_rdata, exp_i_rdata);
    chk1("t1_pmem_read_drop", pmem_read, 1'b0);
    chk1("t1_d_resp", d_resp, 1'b0);
    i_read = 1'b0;
    cyc();
    chk1("t1_i_resp_once", i_resp, 1'b0);
    chkl("t1_i_rdata_hold", i_rdata, exp_i_rdata);

    // T2: D write-back with L=1; pmem_resp also held into DONE (ignored)
    d_write   = 1'b1;
    d_address = 16'h4000;
    d_wdata   = line_wb;
    cyc();
    chk1("t2_pmem_write", pmem_write, 1'b1);
    chk1("t2_pmem_read", pmem_read, 1'b0);
    chk16("t2_pmem_address", pmem_address, 16'h4000);
    chkl("t2_pmem_wdata", pmem_wdata, line_wb);
    cyc();
    chk1("t2_pmem_write_c2", pmem_write, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = line_x;
    cyc();
    chk1("t2_d_resp", d_resp, 1'b1);
    chk1("t2_i_resp", i_resp, 1'b0);
    chk1("t2_pmem_write_drop", pmem_write, 1'b0);
    chkl("t2_d_rdata_unchanged", d_rdata, exp_d_rdata);
    d_write = 1'b0;
    cyc();
    pmem_resp = 1'b0;
    chk1("t2_d_resp_once", d_resp, 1'b0);
    chk1("t2_no_regrant", pmem_write | pmem_read, 1'b0);

    // T3: simultaneous pair after reset -> D, then I; next pair -> I, then D
    reset = 1'b1;
    cyc();
    reset       = 1'b0;
    exp_i_rdata = '0;
    i_read      = 1'b1;
    i_address   = 16'h2000;
    d_read      = 1'b1;
    d_address   = 16'h3000;
    cyc();
    chk1("t3_d_first_read", pmem_read, 1'b1);
    chk16("t3_d_first_addr", pmem_address, 16'h3000);
    cyc();
    pmem_resp  = 1'b1;
    pmem_rdata = {8{16'h1111}};
    cyc();
    pmem_resp   = 1'b0;
    exp_d_rdata = {8{16'h1111}};
    chk1("t3_d_resp", d_resp, 1'b1);
    chk1("t3_i_resp_none", i_resp, 1'b0);
    chkl("t3_d_rdata", d_rdata, exp_d_rdata);
    chk1("t3_no_grant_in_done", pmem_read, 1'b0);
    d_read = 1'b0;
    cyc();
    // IDLE: held i_read plus a fresh d_read; last grant was D
    chk1("t3_idle_no_strobe", pmem_read, 1'b0);
    d_read    = 1'b1;
    d_address = 16'h3100;
    cyc();
    chk16("t3_i_second_addr", pmem_address, 16'h2000);
    chk1("t3_i_second_read", pmem_read, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = {8{16'h2222}};
    cyc();
    pmem_resp   = 1'b0;
    exp_i_rdata = {8{16'h2222}};
    chk1("t3_i_resp", i_resp, 1'b1);
    chkl("t3_i_rdata", i_rdata, exp_i_rdata);
    i_read = 1'b0;
    cyc();
    cyc();
    chk16("t3_d_third_addr", pmem_address, 16'h3100);
    chk1("t3_d_third_read", pmem_read, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = {8{16'h3333}};
    cyc();
    pmem_resp   = 1'b0;
    exp_d_rdata = {8{16'h3333}};
    chk1("t3_d_resp2", d_resp, 1'b1);
    chkl("t3_d_rdata2", d_rdata, exp_d_rdata);
    chkl("t3_i_rdata_hold", i_rdata, exp_i_rdata);
    d_read = 1'b0;
    cyc();

    // T5: spurious pmem_resp in IDLE
    pmem_resp  = 1'b1;
    pmem_rdata = line_x;
    cyc();
    pmem_resp = 1'b0;
    cyc();
    chk1("t5_i_resp", i_resp, 1'b0);
    chk1("t5_d_resp", d_resp, 1'b0);
    chk1("t5_pmem_read", pmem_read, 1'b0);
    chkl("t5_i_rdata_hold", i_rdata, exp_i_rdata);
    chkl("t5_d_rdata_hold", d_rdata, exp_d_rdata);

    // T4: reset during BUSY_D, memory never answers
    d_read    = 1'b1;
    d_address = 16'h5000;
    cyc();
    chk1("t4_busy_read", pmem_read, 1'b1);
    reset  = 1'b1;
    d_read = 1'b0;
    cyc();
    reset       = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    chk1("t4_read_dropped", pmem_read, 1'b0);
    chk1("t4_no_d_resp", d_resp, 1'b0);
    chk16("t4_addr_cleared", pmem_address, 16'h0000);
    cyc();
    chk1("t4_no_d_resp_later", d_resp, 1'b0);
    i_read    = 1'b1;
    i_address = 16'h6000;
    cyc();
    chk1("t4_i_read", pmem_read, 1'b1);
    chk16("t4_i_addr", pmem_address, 16'h6000);
    cyc();
    pmem_resp  = 1'b1;
    pmem_rdata = {8{16'h6666}};
    cyc();
    pmem_resp   = 1'b0;
    exp_i_rdata = {8{16'h6666}};
    chk1("t4_i_resp", i_resp, 1'b1);
    chkl("t4_i_rdata", i_rdata, exp_i_rdata);
    i_read = 1'b0;
    cyc();

    // T6: d_read and d_write together -> served as a write
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h7000;
    d_wdata   = line_x;
    cyc();
    chk1("t6_write", pmem_write, 1'b1);
    chk1("t6_not_read", pmem_read, 1'b0);
    chkl("t6_wdata", pmem_wdata, line_x);
    cyc();
    pmem_resp  = 1'b1;
    pmem_rdata = line_a5;
    cyc();
    pmem_resp = 1'b0;
    chk1("t6_d_resp", d_resp, 1'b1);
    chkl("t6_d_rdata_unchanged", d_rdata, exp_d_rdata);
    d_read  = 1'b0;
    d_write = 1'b0;
    cyc();
    chk1("t6_idle", pmem_write, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
